// File: rtl/chess_board_mem_if.sv
// Command channel of the chess board memory: request/ready handshake plus status.
interface chess_board_mem_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_src;
    logic [5:0] cmd_dst;
    logic [3:0] cmd_color;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_color,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_color,
        output cmd_ready, busy, done
    );
endinterface

// File: rtl/chess_board_mem.sv
// 64-square chess board store read by the VGA scanner and edited by a command FSM.
// Define CHESS_LAST_MOVE_HL_EN to paint the most recent move's squares green.
module chess_board_mem (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    input  logic [11:0]      chess_address,
    output logic [31:0]      chess_data,
    chess_board_mem_if.slave cmd
);
    localparam logic [1:0] OP_MOVE  = 2'd0;
    localparam logic [1:0] OP_HL    = 2'd1;
    localparam logic [1:0] OP_CLR   = 2'd2;
    localparam logic [3:0] COL_BLACK = 4'b1000;
    localparam logic [3:0] COL_WHITE = 4'b0100;
    localparam logic [3:0] COL_GREEN = 4'b0001;

`ifdef CHESS_LAST_MOVE_HL_EN
    typedef enum logic [2:0] {IDLE, INIT, CLR, MV_DST, MV_SRC, HL, MV_UNHL, MV_HL} state_t;
`else
    typedef enum logic [2:0] {IDLE, INIT, CLR, MV_DST, MV_SRC, HL} state_t;
`endif

    // Squares with even row+col are dark; row[0]==col[0] is the same test.
    function automatic logic [3:0] baseColor(input logic [5:0] sq);
        return (sq[3] ^ sq[0]) ? COL_WHITE : COL_BLACK;
    endfunction

    function automatic logic [3:0] startPiece(input logic [5:0] sq);
        logic [2:0] kind;
        case (sq[2:0])
            3'd0, 3'd7: kind = 3'd5;
            3'd1, 3'd6: kind = 3'd1;
            3'd2, 3'd5: kind = 3'd4;
            3'd3:       kind = 3'd3;
            default:    kind = 3'd2;
        endcase
        case (sq[5:3])
            3'd0:    return {kind, 1'b0};
            3'd1:    return {3'd6, 1'b0};
            3'd6:    return {3'd6, 1'b1};
            3'd7:    return {kind, 1'b1};
            default: return 4'd0;
        endcase
    endfunction

    state_t     state_reg, state_next;
    logic [5:0] cnt_reg, cnt_next;
    logic [5:0] opSrc_reg, opSrc_next;
    logic [5:0] opDst_reg, opDst_next;
    logic [3:0] opColor_reg, opColor_next;
    logic       samePos_reg, samePos_next;
    logic       initCmd_reg, initCmd_next;
    logic [3:0] movePiece_reg;
`ifdef CHESS_LAST_MOVE_HL_EN
    logic [5:0] lastSrc_reg, lastSrc_next;
    logic [5:0] lastDst_reg, lastDst_next;
    logic       lastValid_reg, lastValid_next;
`endif

    logic       readyC, busyC, doneC;
    logic       accept;
    logic       hlOk;
    logic       pieceWe;
    logic [5:0] pieceWrAddr;
    logic [3:0] pieceWrData;
    logic       colorWeA, colorWeB;
    logic [5:0] colorAddrA, colorAddrB;
    logic [3:0] colorDataA, colorDataB;

    // Piece nibbles live in a single-write-port array; colours in per-square
    // registers because last-move painting touches two squares in one cycle.
    logic [3:0] pieceMem [0:63];
    logic [3:0] sqColor [64];

    assign accept = cmd.cmd_valid && (state_reg == IDLE);
    assign hlOk   = (opColor_reg != 4'd0) && ((opColor_reg & (opColor_reg - 4'd1)) == 4'd0);

    always_ff @(posedge iVGA_CLK) begin
        if (pieceWe)
            pieceMem[pieceWrAddr] <= pieceWrData;
    end

    // Source piece is taken at accept so later input changes cannot affect the move.
    always_ff @(posedge iVGA_CLK) begin
        if (accept)
            movePiece_reg <= pieceMem[cmd.cmd_src];
    end

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_sq
            logic [3:0] color_reg;
            always_ff @(posedge iVGA_CLK) begin
                if (colorWeA && (colorAddrA == 6'(gi)))
                    color_reg <= colorDataA;
                else if (colorWeB && (colorAddrB == 6'(gi)))
                    color_reg <= colorDataB;
            end
            assign sqColor[gi] = color_reg;
        end
    endgenerate

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            chess_data <= 32'd0;
        else if (chess_address[11:6] != 6'd0)
            chess_data <= 32'd0;
        else
            chess_data <= {24'd0, sqColor[chess_address[5:0]], pieceMem[chess_address[5:0]]};
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg     <= INIT;
            cnt_reg       <= 6'd0;
            opSrc_reg     <= 6'd0;
            opDst_reg     <= 6'd0;
            opColor_reg   <= 4'd0;
            samePos_reg   <= 1'b0;
            initCmd_reg   <= 1'b0;
`ifdef CHESS_LAST_MOVE_HL_EN
            lastSrc_reg   <= 6'd0;
            lastDst_reg   <= 6'd0;
            lastValid_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            opSrc_reg     <= opSrc_next;
            opDst_reg     <= opDst_next;
            opColor_reg   <= opColor_next;
            samePos_reg   <= samePos_next;
            initCmd_reg   <= initCmd_next;
`ifdef CHESS_LAST_MOVE_HL_EN
            lastSrc_reg   <= lastSrc_next;
            lastDst_reg   <= lastDst_next;
            lastValid_reg <= lastValid_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        opSrc_next     = opSrc_reg;
        opDst_next     = opDst_reg;
        opColor_next   = opColor_reg;
        samePos_next   = samePos_reg;
        initCmd_next   = initCmd_reg;
`ifdef CHESS_LAST_MOVE_HL_EN
        lastSrc_next   = lastSrc_reg;
        lastDst_next   = lastDst_reg;
        lastValid_next = lastValid_reg;
`endif
        readyC      = 1'b0;
        busyC       = 1'b1;
        doneC       = 1'b0;
        pieceWe     = 1'b0;
        pieceWrAddr = cnt_reg;
        pieceWrData = 4'd0;
        colorWeA    = 1'b0;
        colorAddrA  = cnt_reg;
        colorDataA  = baseColor(cnt_reg);
        colorWeB    = 1'b0;
        colorAddrB  = 6'd0;
        colorDataB  = 4'd0;

        case (state_reg)
            IDLE: begin
                readyC = 1'b1;
                busyC  = 1'b0;
                if (cmd.cmd_valid) begin
                    opSrc_next   = cmd.cmd_src;
                    opDst_next   = cmd.cmd_dst;
                    opColor_next = cmd.cmd_color;
                    samePos_next = (cmd.cmd_src == cmd.cmd_dst);
                    cnt_next     = 6'd0;
                    case (cmd.cmd_op)
`ifdef CHESS_LAST_MOVE_HL_EN
                        OP_MOVE: state_next = lastValid_reg ? MV_UNHL : MV_DST;
`else
                        OP_MOVE: state_next = MV_DST;
`endif
                        OP_HL:   state_next = HL;
                        OP_CLR:  state_next = CLR;
                        default: begin
                            state_next   = INIT;
                            initCmd_next = 1'b1;
                        end
                    endcase
                end
            end
            INIT, CLR: begin
                colorWeA = 1'b1;
                if (state_reg == INIT) begin
                    pieceWe     = 1'b1;
                    pieceWrData = startPiece(cnt_reg);
                end
                if (cnt_reg == 6'd63) begin
                    state_next   = IDLE;
                    cnt_next     = 6'd0;
                    // The power-up sweep is not a command, so it stays silent.
                    doneC        = (state_reg == CLR) || initCmd_reg;
                    initCmd_next = 1'b0;
`ifdef CHESS_LAST_MOVE_HL_EN
                    lastValid_next = 1'b0;
`endif
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
`ifdef CHESS_LAST_MOVE_HL_EN
            MV_UNHL: begin
                colorWeA   = !samePos_reg;
                colorAddrA = lastSrc_reg;
                colorDataA = baseColor(lastSrc_reg);
                colorWeB   = !samePos_reg;
                colorAddrB = lastDst_reg;
                colorDataB = baseColor(lastDst_reg);
                state_next = MV_DST;
            end
`endif
            MV_DST: begin
                pieceWe     = !samePos_reg;
                pieceWrAddr = opDst_reg;
                pieceWrData = movePiece_reg;
                state_next  = MV_SRC;
            end
            MV_SRC: begin
                pieceWe     = !samePos_reg;
                pieceWrAddr = opSrc_reg;
                pieceWrData = 4'd0;
`ifdef CHESS_LAST_MOVE_HL_EN
                state_next  = MV_HL;
`else
                state_next  = IDLE;
                doneC       = 1'b1;
`endif
            end
`ifdef CHESS_LAST_MOVE_HL_EN
            MV_HL: begin
                colorWeA   = !samePos_reg;
                colorAddrA = opSrc_reg;
                colorDataA = COL_GREEN;
                colorWeB   = !samePos_reg;
                colorAddrB = opDst_reg;
                colorDataB = COL_GREEN;
                if (!samePos_reg) begin
                    lastSrc_next   = opSrc_reg;
                    lastDst_next   = opDst_reg;
                    lastValid_next = 1'b1;
                end
                state_next = IDLE;
                doneC      = 1'b1;
            end
`endif
            HL: begin
                colorWeA   = hlOk;
                colorAddrA = opSrc_reg;
                colorDataA = opColor_reg;
                state_next = IDLE;
                doneC      = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = readyC;
    assign cmd.busy      = busyC;
    assign cmd.done      = doneC;
endmodule

// File: tb/tb_chess_board_mem.sv
// Randomized self-checking bench for chess_board_mem against a square-level board model.
`timescale 1ns/1ps
module tb_chess_board_mem;
    logic        iVGA_CLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [11:0] chess_address = 12'd0;
    logic [31:0] chess_data;

    chess_board_mem_if bus();

    chess_board_mem dut (
        .iVGA_CLK      (iVGA_CLK),
        .iRST_n        (iRST_n),
        .chess_address (chess_address),
        .chess_data    (chess_data),
        .cmd           (bus)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    localparam int BACK_RANK [8] = '{5, 1, 4, 3, 2, 4, 1, 5};

    int errCount = 0;
    int checkCount = 0;
    bit [7:0] refBoard [64];
`ifdef CHESS_LAST_MOVE_HL_EN
    bit lastValid = 1'b0;
    int lastSrc = 0;
    int lastDst = 0;
`endif

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] baseByte(input int sq);
        return (((sq / 8) + (sq % 8)) % 2 == 0) ? 8'h80 : 8'h40;
    endfunction

    function automatic void refInit();
        for (int sq = 0; sq < 64; sq++) begin
            int row, col, kind, black;
            row = sq / 8;
            col = sq % 8;
            kind = (row == 0 || row == 7) ? BACK_RANK[col] : ((row == 1 || row == 6) ? 6 : 0);
            black = (row >= 6) ? 1 : 0;
            refBoard[sq] = baseByte(sq) | 8'(kind * 2 + black);
        end
`ifdef CHESS_LAST_MOVE_HL_EN
        lastValid = 1'b0;
`endif
    endfunction

    function automatic void refApply(input int op, input int src, input int dst, input int color);
        bit [3:0] c4;
        bit [7:0] low;
        c4 = 4'(color);
        case (op)
            0: if (src != dst) begin
`ifdef CHESS_LAST_MOVE_HL_EN
                if (lastValid) begin
                    refBoard[lastSrc] = baseByte(lastSrc) | (refBoard[lastSrc] & 8'h0F);
                    refBoard[lastDst] = baseByte(lastDst) | (refBoard[lastDst] & 8'h0F);
                end
`endif
                low = refBoard[src] & 8'h0F;
                refBoard[dst] = (refBoard[dst] & 8'hF0) | low;
                refBoard[src] = refBoard[src] & 8'hF0;
`ifdef CHESS_LAST_MOVE_HL_EN
                refBoard[src] = 8'h10 | (refBoard[src] & 8'h0F);
                refBoard[dst] = 8'h10 | (refBoard[dst] & 8'h0F);
                lastValid = 1'b1;
                lastSrc = src;
                lastDst = dst;
`endif
            end
            1: if ($countones(c4) == 1) refBoard[src] = {c4, refBoard[src][3:0]};
            2: begin
                for (int sq = 0; sq < 64; sq++)
                    refBoard[sq] = baseByte(sq) | (refBoard[sq] & 8'h0F);
`ifdef CHESS_LAST_MOVE_HL_EN
                lastValid = 1'b0;
`endif
            end
            default: refInit();
        endcase
    endfunction

    function automatic int expectedLatency(input int op);
        if (op == 1) return 1;
        if (op >= 2) return 64;
`ifdef CHESS_LAST_MOVE_HL_EN
        return lastValid ? 4 : 3;
`else
        return 2;
`endif
    endfunction

    task automatic waitReady();
        int guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            @(posedge iVGA_CLK); #1;
            guard++;
        end
    endtask

    task automatic readExpect(input int addr, input logic [31:0] expv, input string tag);
        chess_address = 12'(addr);
        @(posedge iVGA_CLK); #1;
        checkVal($sformatf("%s @%03h", tag, addr), chess_data, expv);
    endtask

    task automatic readModel(input int addr, input string tag);
        readExpect(addr, (addr >= 64) ? 32'd0 : 32'(refBoard[addr]), tag);
    endtask

    task automatic compareBoard(input string tag);
        for (int sq = 0; sq < 64; sq++)
            readModel(sq, tag);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " chess_data"}, chess_data, 32'd0);
        checkVal({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        checkVal({tag, " busy"}, 32'(bus.busy), 32'd1);
        checkVal({tag, " done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic waitInitAfterReset(input string tag);
        int cyc = 0;
        bit doneSeen = 1'b0;
        while (!bus.cmd_ready && cyc < 200) begin
            @(posedge iVGA_CLK); #1;
            cyc++;
            if (bus.done) doneSeen = 1'b1;
        end
        checkVal({tag, " init cycles"}, 32'(cyc), 32'd64);
        checkVal({tag, " init done quiet"}, 32'(doneSeen), 32'd0);
        refInit();
    endtask

    task automatic runCmd(input int op, input int src, input int dst, input int color,
                          input int spurious, input string tag);
        int lat, expLat;
        bit readySeen = 1'b0;
        expLat = expectedLatency(op);
        waitReady();
        checkVal({tag, " ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_src   = 6'(src);
        bus.cmd_dst   = 6'(dst);
        bus.cmd_color = 4'(color);
        @(posedge iVGA_CLK); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_src   = 6'($urandom);
        bus.cmd_dst   = 6'($urandom);
        bus.cmd_color = 4'($urandom);
        checkVal({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (lat <= spurious) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'd1;
                bus.cmd_color = 4'b0001;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.cmd_ready) readySeen = 1'b1;
            @(posedge iVGA_CLK); #1;
            lat++;
        end
        bus.cmd_valid = 1'b0;
        if (spurious > 0) checkVal({tag, " ready while busy"}, 32'(readySeen), 32'd0);
        checkVal({tag, " latency"}, 32'(lat), 32'(expLat));
        @(posedge iVGA_CLK); #1;
        checkVal({tag, " done pulse"}, 32'(bus.done), 32'd0);
        checkVal({tag, " ready after"}, 32'(bus.cmd_ready), 32'd1);
        refApply(op, src, dst, color);
    endtask

    // A display read of the square being highlighted must see the old byte.
    task automatic preWriteTest(input int sq, input int color);
        logic [7:0] oldv;
        waitReady();
        oldv = refBoard[sq];
        chess_address = 12'(sq);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_src   = 6'(sq);
        bus.cmd_color = 4'(color);
        @(posedge iVGA_CLK); #1;
        bus.cmd_valid = 1'b0;
        checkVal("prewrite done", 32'(bus.done), 32'd1);
        @(posedge iVGA_CLK); #1;
        checkVal("prewrite old", chess_data, 32'(oldv));
        refApply(1, sq, 0, color);
        @(posedge iVGA_CLK); #1;
        checkVal("prewrite new", chess_data, 32'(refBoard[sq]));
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_src   = 6'd0;
        bus.cmd_dst   = 6'd0;
        bus.cmd_color = 4'd0;

        repeat (3) @(posedge iVGA_CLK);
        #1;
        checkResetOutputs("reset");
        iRST_n = 1'b1;
        waitInitAfterReset("por");

        readExpect(12'h000, 32'h8A, "start");
        readExpect(12'h004, 32'h84, "start");
        readExpect(12'h00C, 32'h4C, "start");
        readExpect(12'h03C, 32'h45, "start");
        readExpect(12'h01C, 32'h40, "start");
        readExpect(12'h040, 32'h00, "oor");
        readExpect(12'hFC5, 32'h00, "oor");
        compareBoard("init");

        runCmd(0, 12, 28, 0, 0, "move1");
        readExpect(12'h00C, 32'h40, "move1");
        readExpect(12'h01C, 32'h4C, "move1");
        runCmd(0, 52, 36, 0, 0, "move2");
        readExpect(12'h00C, 32'h40, "move2");
        readExpect(12'h01C, 32'h4C, "move2");
`ifdef CHESS_LAST_MOVE_HL_EN
        readExpect(12'h034, 32'h10, "move2");
        readExpect(12'h024, 32'h1D, "move2");
`else
        readExpect(12'h034, 32'h80, "move2");
        readExpect(12'h024, 32'h8D, "move2");
`endif
        runCmd(0, 1, 1, 0, 0, "same");
        readModel(1, "same");

        runCmd(1, 0, 0, 2, 0, "hl");
        readExpect(12'h000, 32'h2A, "hl");
        runCmd(1, 0, 0, 3, 0, "hl multi");
        readExpect(12'h000, 32'h2A, "hl multi");
        preWriteTest(9, 1);
        runCmd(2, 0, 0, 0, 10, "clr");
        readExpect(12'h000, 32'h8A, "clr");
        compareBoard("clr");

        // Abort a CLR mid-sweep with an asynchronous reset pulse.
        waitReady();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        @(posedge iVGA_CLK); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge iVGA_CLK);
        #3 iRST_n = 1'b0;
        #1 checkResetOutputs("midreset");
        @(posedge iVGA_CLK);
        @(posedge iVGA_CLK); #1;
        iRST_n = 1'b1;
        waitInitAfterReset("midreset");
        compareBoard("midreset");

        for (int i = 0; i < 60; i++) begin
            int sel, op, src, dst, color;
            sel = int'($urandom_range(0, 99));
            op = (sel < 55) ? 0 : ((sel < 85) ? 1 : ((sel < 93) ? 2 : 3));
            src = int'($urandom_range(0, 63));
            dst = ($urandom_range(0, 7) == 0) ? src : int'($urandom_range(0, 63));
            color = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(0, 3)) : int'($urandom_range(0, 15));
            runCmd(op, src, dst, color, 0, $sformatf("rnd%0d op%0d", i, op));
            readModel(src, "rnd src");
            readModel(dst, "rnd dst");
            readModel(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4095)), "rnd any");
        end
        compareBoard("final");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/chess_board_mem.md
CHESS_BOARD_MEM -- requirements
Module: chess_board_mem

Interface
REQ-001 SHALL: iRST_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL: iVGA_CLK  in  1  sole clock; every flop on posedge.
REQ-003 SHALL: chess_address  in  12  display read address {6'b0,row[2:0],col[2:0]}, row 0 = rank 1.
REQ-004 SHALL: chess_data  out  32  registered square word, zero-extended from 8 bits.
REQ-005 SHALL: cmd_valid  in  1  command request.
REQ-006 SHALL: cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-007 SHALL: cmd_op  in  2  0 MOVE, 1 HIGHLIGHT, 2 CLEAR_HL, 3 INIT.
REQ-008 SHALL: cmd_src  in  6  {row,col}; MOVE source or HIGHLIGHT target.
REQ-009 SHALL: cmd_dst  in  6  MOVE destination.
REQ-010 SHALL: cmd_color  in  4  HIGHLIGHT colour, one-hot.
REQ-011 SHALL: busy  out  1  high whenever the FSM is not IDLE.
REQ-012 SHALL: done  out  1  one-cycle pulse on the final cycle of every accepted command.

Function
REQ-013 SHALL: store 64 x 8-bit words; [0] piece colour (0 white, 1 black), [3:1] type (0 none, 1 knight, 2 king, 3 queen, 4 bishop, 5 rook, 6 pawn), [7:4] square colour one-hot (8 black, 4 white, 2 red, 1 green).
REQ-014 SHALL: base colour = black when row+col is even, else white.
REQ-015 SHALL: register chess_data one cycle after chess_address; chess_address[11:6] != 0 returns 0.
REQ-016 SHALL: a display read of a square written in the same cycle returns the pre-write value.
REQ-017 SHALL: FSM states IDLE, INIT, CLR, MV_DST, MV_SRC, HL; plus MV_UNHL, MV_HL when the REQ-028 feature is present.
REQ-018 SHALL: INIT write squares 0..63 one per cycle (64 cycles) with the standard start position and base colours; back-rank type order by column is 5,1,4,3,2,4,1,5; row 1 is white pawns; row 6 is black pawns; row 7 is the black back rank.
REQ-019 SHALL: CLR restore [7:4] of all 64 squares to base colour over 64 cycles, with pieces untouched.
REQ-020 SHALL: MOVE capture the src piece bits at accept; in MV_DST write dst[3:0] = captured bits; in MV_SRC write src[3:0] = 0; square colours are preserved; total latency is 2 cycles after accept.
REQ-021 SHALL: MOVE with src == dst leave memory unchanged and still pulse done.
REQ-022 SHALL: HIGHLIGHT write target [7:4] = cmd_color in one cycle (HL); a zero or multi-hot cmd_color performs no write but still pulses done.
REQ-023 SHALL: the counter used for INIT/CLR be 6 bits; done asserts on index 63; no wrap beyond it.
REQ-024 SHALL: ignore cmd_valid while busy; inputs are sampled only at accept.

Reset
REQ-025 SHALL: on iRST_n low, immediately set chess_data=0, done=0, cmd_ready=0, busy=1 and counter=0.
REQ-026 SHALL: after reset release, enter INIT automatically; the first command is accepted after 64 cycles; the automatic INIT does not pulse done.
REQ-027 SHALL: reset asserted mid-command abort that command and restart INIT after release.

Configuration
REQ-028 SHALL: with CHESS_LAST_MOVE_HL_EN defined, MOVE first restores base colour on the previous move's src/dst (MV_UNHL, 1 cycle, skipped if none), then runs MV_DST/MV_SRC, then paints both squares green (MV_HL, 1 cycle); latency is 4 cycles (3 cycles when there is no previous move); INIT and CLR forget the previous move.
REQ-029 SHALL: without CHESS_LAST_MOVE_HL_EN, MOVE is exactly as REQ-020, and no last-move registers exist.

Verification
REQ-030 SHALL: reset then wait 64 cycles -> read 0x000=0x8A, 0x004=0x84, 0x00C=0x4C, 0x03C=0x45, 0x01C=0x40.
REQ-031 SHALL: MOVE src=12 dst=28 (macro off) -> done 2 cycles after accept; 0x00C=0x40; 0x01C=0x4C.
REQ-032 SHALL: macro on, MOVE 12->28 then MOVE 52->36 -> after the second move 0x00C=0x40, 0x01C=0x4C, 0x034=0x10, 0x024=0x1D.
REQ-033 SHALL: HIGHLIGHT src=0 color=2 -> 0x000=0x2A; then CLR -> 0x000=0x8A, done 64 cycles after accept.
REQ-034 SHALL: HIGHLIGHT color=4'b0011 -> no change, done pulses; cmd_valid while busy -> not accepted.
REQ-035 SHALL: iRST_n pulsed during CLR -> cmd_ready low for 64 cycles after release, then board equals REQ-030 values.
